// File: rtl/ept_pkg.sv
// Shared types and constants for the EPT translate requester.
// Cache entries store page numbers (address >> PAGE_SHIFT) in full
// 64-bit fields so the layout does not depend on the PAGE_SHIFT parameter.
package ept_pkg;

  typedef logic [7:0]  vmid_t;
  typedef logic [63:0] addr_t;

  localparam int PAGE_SHIFT_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic  valid;
    vmid_t vmid;
    addr_t tag;   // guest page number
    addr_t hpn;   // host page number
  } tlb_entry_t;

  // Mask covering the untranslated page-offset bits.
  function automatic addr_t offset_mask(input int page_shift);
    return addr_t'((64'd1 << page_shift) - 64'd1);
  endfunction

endpackage

// File: rtl/ept_tlb.sv
// Fully-associative VMID-tagged GPA-page -> HPA-page cache.
// Lookup is purely combinational against the registered entry array.
// Fill goes to the lowest invalid entry, otherwise to the round-robin
// victim (which then advances). An invalidate that matches the fill's
// VMID in the same cycle drops the fill entirely, victim pointer included.
module ept_tlb
  import ept_pkg::*;
#(
  parameter int ENTRIES    = 8,
  parameter int PAGE_SHIFT = PAGE_SHIFT_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  vmid_t lookup_vmid,
  input  addr_t lookup_gpa,
  output logic  hit,
  output addr_t hit_hpn,
  input  logic  fill_en,
  input  vmid_t fill_vmid,
  input  addr_t fill_gpa,
  input  addr_t fill_hpa,
  input  logic  inv_valid,
  input  logic  inv_all,
  input  vmid_t inv_vmid
);

  localparam int IW = $clog2(ENTRIES);

  tlb_entry_t     entries [ENTRIES];
  logic [IW-1:0]  victim;
  logic [IW-1:0]  free_idx;
  logic           free_found;
  logic [IW-1:0]  fill_idx;
  logic           fill_drop;
  logic           do_fill;

  // Parallel tag compare across all entries.
  always_comb begin
    hit     = 1'b0;
    hit_hpn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (entries[i].valid && (entries[i].vmid == lookup_vmid) &&
          (entries[i].tag == (lookup_gpa >> PAGE_SHIFT))) begin
        hit     = 1'b1;
        hit_hpn = entries[i].hpn;
      end
    end
  end

  // Lowest-numbered invalid entry, scanning down so index 0 wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entries[i].valid) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign fill_drop = inv_valid && (inv_all || (inv_vmid == fill_vmid));
  assign do_fill   = fill_en && !fill_drop;
  assign fill_idx  = free_found ? free_idx : victim;

  // Entry array, victim pointer, invalidate and fill update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) entries[i] <= '0;
      victim <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (inv_valid && (inv_all || (entries[i].vmid == inv_vmid)))
          entries[i].valid <= 1'b0;
      end
      if (do_fill) begin
        entries[fill_idx] <= '{valid: 1'b1,
                               vmid:  fill_vmid,
                               tag:   fill_gpa >> PAGE_SHIFT,
                               hpn:   fill_hpa >> PAGE_SHIFT};
        if (!free_found) victim <= victim + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ept_req.sv
// Client-side EPT translate requester: one request in flight, cache
// lookup in the accept cycle, single-cycle walk on a miss, held response.
// Optional hit/miss counters are enabled by defining EPT_REQ_STATS_EN.
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; a held response stays stable until then.
module ept_req
  import ept_pkg::*;
#(
  parameter int ENTRIES    = 8,
  parameter int PAGE_SHIFT = PAGE_SHIFT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  vmid_t       req_vmid_i,
  input  addr_t       req_gpa_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output addr_t       resp_hpa_o,
  output logic        resp_fault_o,
  output logic        ept_valid_o,
  output vmid_t       ept_vmid_o,
  output addr_t       ept_gpa_o,
  input  addr_t       ept_hpa_i,
  input  logic        ept_fault_i,
  input  logic        inv_valid_i,
  input  logic        inv_all_i,
  input  vmid_t       inv_vmid_i,
`ifdef EPT_REQ_STATS_EN
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o,
`endif
  output state_t      dbg_state_o
);

  localparam addr_t OFF_MASK = offset_mask(PAGE_SHIFT);

  state_t state;
  vmid_t  vmid_q;
  addr_t  gpa_q;
  logic   accept;
  logic   hit;
  addr_t  hit_hpn;
  logic   walking;

  assign req_ready_o = (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign walking     = (state == WALK);
  assign dbg_state_o = state;

  assign ept_valid_o = walking;
  assign ept_vmid_o  = walking ? vmid_q : '0;
  assign ept_gpa_o   = walking ? (gpa_q & ~OFF_MASK) : '0;

  ept_tlb #(
    .ENTRIES    (ENTRIES),
    .PAGE_SHIFT (PAGE_SHIFT)
  ) u_tlb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_vmid (req_vmid_i),
    .lookup_gpa  (req_gpa_i),
    .hit         (hit),
    .hit_hpn     (hit_hpn),
    .fill_en     (walking && !ept_fault_i),
    .fill_vmid   (vmid_q),
    .fill_gpa    (gpa_q),
    .fill_hpa    (ept_hpa_i),
    .inv_valid   (inv_valid_i),
    .inv_all     (inv_all_i),
    .inv_vmid    (inv_vmid_i)
  );

  // Request FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      vmid_q       <= '0;
      gpa_q        <= '0;
      resp_valid_o <= 1'b0;
      resp_hpa_o   <= '0;
      resp_fault_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vmid_q <= req_vmid_i;
            gpa_q  <= req_gpa_i;
            if (hit) begin
              resp_valid_o <= 1'b1;
              resp_hpa_o   <= (hit_hpn << PAGE_SHIFT) | (req_gpa_i & OFF_MASK);
              resp_fault_o <= 1'b0;
              state        <= RESP;
            end else begin
              state <= WALK;
            end
          end
        end
        WALK: begin
          resp_valid_o <= 1'b1;
          resp_fault_o <= ept_fault_i;
          resp_hpa_o   <= ept_fault_i ? '0
                          : ((ept_hpa_i & ~OFF_MASK) | (gpa_q & OFF_MASK));
          state        <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EPT_REQ_STATS_EN
  // Saturating hit/miss counters; invalidates leave them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (accept) begin
      if (hit && (hit_cnt_o != '1))   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (!hit && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ept_req.sv
// Self-checking bench for ept_req: directed scenarios followed by random
// traffic, all checked against an array-based cache model and a queue of
// expected responses.
module tb_ept_req;
  import ept_pkg::*;

  localparam int    NE  = 8;
  localparam addr_t OFF = 64'hFFF;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   req_valid_i = 1'b0;
  logic   req_ready_o;
  vmid_t  req_vmid_i = '0;
  addr_t  req_gpa_i = '0;
  logic   resp_valid_o;
  logic   resp_ready_i = 1'b0;
  addr_t  resp_hpa_o;
  logic   resp_fault_o;
  logic   ept_valid_o;
  vmid_t  ept_vmid_o;
  addr_t  ept_gpa_o;
  addr_t  ept_hpa_i = '0;
  logic   ept_fault_i = 1'b0;
  logic   inv_valid_i = 1'b0;
  logic   inv_all_i = 1'b0;
  vmid_t  inv_vmid_i = '0;
  state_t dbg_state;

  always #5 clk = ~clk;

  ept_req dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_vmid_i   (req_vmid_i),
    .req_gpa_i    (req_gpa_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_hpa_o   (resp_hpa_o),
    .resp_fault_o (resp_fault_o),
    .ept_valid_o  (ept_valid_o),
    .ept_vmid_o   (ept_vmid_o),
    .ept_gpa_o    (ept_gpa_o),
    .ept_hpa_i    (ept_hpa_i),
    .ept_fault_i  (ept_fault_i),
    .inv_valid_i  (inv_valid_i),
    .inv_all_i    (inv_all_i),
    .inv_vmid_i   (inv_vmid_i),
    .dbg_state_o  (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [64:0] exp_q[$];   // {fault, hpa}

  // Reference cache: page numbers kept as plain 64-bit values.
  logic  m_valid  [NE];
  vmid_t m_vmid   [NE];
  addr_t m_gpn    [NE];
  addr_t m_hpn    [NE];
  int    m_victim;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 1'b0; m_vmid[i] = '0; m_gpn[i] = '0; m_hpn[i] = '0;
    end
    m_victim = 0;
  endtask

  task automatic m_lookup(input vmid_t vmid, input addr_t gpa, output bit hit, output addr_t hpa);
    hit = 0; hpa = '0;
    for (int i = 0; i < NE; i++)
      if (m_valid[i] && m_vmid[i] == vmid && m_gpn[i] == gpa / 4096) begin
        hit = 1; hpa = m_hpn[i] * 4096 + gpa % 4096;
      end
  endtask

  task automatic m_inv(input bit all, input vmid_t vmid);
    for (int i = 0; i < NE; i++)
      if (all || m_vmid[i] == vmid) m_valid[i] = 1'b0;
  endtask

  // Effect of the clock edge that ends a walk.
  task automatic m_walk(input vmid_t vmid, input addr_t gpa, input addr_t ehpa, input bit fault,
                        input bit inv, input bit inv_all, input vmid_t inv_vmid);
    int idx = -1;
    bit use_victim;
    for (int i = 0; i < NE; i++) if (idx < 0 && !m_valid[i]) idx = i;
    use_victim = (idx < 0);
    if (use_victim) idx = m_victim;
    if (inv) m_inv(inv_all, inv_vmid);
    if (!fault && !(inv && (inv_all || inv_vmid == vmid))) begin
      m_valid[idx] = 1'b1; m_vmid[idx] = vmid;
      m_gpn[idx] = gpa / 4096; m_hpn[idx] = ehpa / 4096;
      if (use_victim) m_victim = (m_victim + 1) % NE;
    end
  endtask

  // One full transaction. inv_when: 0 none, 1 during WALK, 2 first held RESP cycle.
  task automatic do_req(input vmid_t vmid, input addr_t gpa, input addr_t ehpa, input bit efault,
                        input int inv_when, input bit inv_all, input vmid_t inv_vmid, input int hold);
    bit          hit;
    addr_t       mhpa;
    logic [64:0] exp;
    check("req_ready_idle", req_ready_o, 1);
    m_lookup(vmid, gpa, hit, mhpa);
    if (hit) exp_q.push_back({1'b0, mhpa});
    else if (efault) exp_q.push_back({1'b1, 64'd0});
    else exp_q.push_back({1'b0, (ehpa & ~OFF) | (gpa & OFF)});
    req_valid_i = 1'b1; req_vmid_i = vmid; req_gpa_i = gpa;
    ept_hpa_i = ehpa; ept_fault_i = efault;
    @(posedge clk); #1;
    req_valid_i = 1'b0; req_vmid_i = vmid_t'($urandom); req_gpa_i = {$urandom, $urandom};
    check("ept_valid_on_miss", ept_valid_o, !hit);
    if (!hit) begin
      check("ept_vmid", ept_vmid_o, vmid);
      check("ept_gpa", ept_gpa_o, gpa & ~OFF);
      check("resp_valid_walk", resp_valid_o, 0);
      check("req_ready_walk", req_ready_o, 0);
      if (inv_when == 1) begin
        inv_valid_i = 1'b1; inv_all_i = inv_all; inv_vmid_i = inv_vmid;
      end
      @(posedge clk); #1;
      inv_valid_i = 1'b0;
      m_walk(vmid, gpa, ehpa, efault, inv_when == 1, inv_all, inv_vmid);
      check("ept_valid_after_walk", ept_valid_o, 0);
      check("ept_gpa_after_walk", ept_gpa_o, 0);
    end
    ept_hpa_i = {$urandom, $urandom}; ept_fault_i = 1'($urandom);
    exp = exp_q.pop_front();
    check("resp_valid", resp_valid_o, 1);
    check("resp_hpa", resp_hpa_o, exp[63:0]);
    check("resp_fault", resp_fault_o, exp[64]);
    for (int h = 0; h < hold; h++) begin
      resp_ready_i = 1'b0;
      if (inv_when == 2 && h == 0) begin
        inv_valid_i = 1'b1; inv_all_i = inv_all; inv_vmid_i = inv_vmid;
      end
      @(posedge clk); #1;
      inv_valid_i = 1'b0;
      if (inv_when == 2 && h == 0) m_inv(inv_all, inv_vmid);
      check("resp_valid_held", resp_valid_o, 1);
      check("resp_hpa_held", resp_hpa_o, exp[63:0]);
      check("resp_fault_held", resp_fault_o, exp[64]);
      check("req_ready_held", req_ready_o, 0);
    end
    resp_ready_i = 1'b1;
    @(posedge clk); #1;
    resp_ready_i = 1'b0;
    check("resp_valid_done", resp_valid_o, 0);
  endtask

  task automatic do_inv(input bit all, input vmid_t vmid);
    inv_valid_i = 1'b1; inv_all_i = all; inv_vmid_i = vmid;
    @(posedge clk); #1;
    inv_valid_i = 1'b0;
    m_inv(all, vmid);
  endtask

  initial begin
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready_o, 1);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_resp_hpa", resp_hpa_o, 0);
    check("rst_resp_fault", resp_fault_o, 0);
    check("rst_ept_valid", ept_valid_o, 0);
    check("rst_ept_vmid", ept_vmid_o, 0);
    check("rst_ept_gpa", ept_gpa_o, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Miss then hit on the same page, then VMID isolation and uncached faults.
    do_req(8'd3, 64'h4000_0123, 64'h5000_0000, 0, 0, 0, 0, 0);
    do_req(8'd3, 64'h4000_0FFF, 64'hDEAD_B000, 0, 0, 0, 0, 0);
    do_req(8'd4, 64'h4000_0123, 64'h6000_0000, 1, 0, 0, 0, 0);
    do_req(8'd4, 64'h4000_0123, 64'h6000_0000, 1, 0, 0, 0, 0);

    // Nine distinct pages into eight entries; pages 1..7 hit before page 0.
    do_inv(1, 0);
    for (int k = 0; k < 9; k++)
      do_req(8'd1, 64'h10_0000 + 64'(k) * 64'h1000 + 64'h10, 64'h8000_0000 + 64'(k) * 64'h1000, 0, 0, 0, 0, 0);
    for (int k = 1; k < 8; k++)
      do_req(8'd1, 64'h10_0000 + 64'(k) * 64'h1000 + 64'h20, 64'hBAD0_0000, 0, 0, 0, 0, 0);
    do_req(8'd1, 64'h10_0000 + 64'h30, 64'h9000_0000, 0, 0, 0, 0, 0);

    // Invalidate racing a walk fill, then flush-all.
    do_req(8'd3, 64'h7000_0456, 64'hA000_0000, 0, 1, 0, 8'd3, 0);
    do_req(8'd3, 64'h7000_0456, 64'hA100_0000, 0, 0, 0, 0, 0);
    do_inv(1, 0);
    do_req(8'd3, 64'h7000_0456, 64'hA200_0000, 0, 0, 0, 0, 0);
    do_req(8'd1, 64'h10_0000 + 64'h2000, 64'hA300_0000, 0, 0, 0, 0, 0);

    // Held response with an invalidate of the hit's own VMID mid-hold.
    do_req(8'd3, 64'h7000_0001, 64'hFFFF_0000, 0, 2, 0, 8'd3, 5);
    do_req(8'd3, 64'h7000_0002, 64'hA400_0000, 0, 0, 0, 0, 0);

    // Random traffic over a small page pool so hits, evictions and races all occur.
    for (int t = 0; t < 200; t++) begin
      vmid_t v   = vmid_t'($urandom_range(0, 3));
      addr_t pg  = 64'($urandom_range(0, 11));
      addr_t gpa = (pg << 12) + 64'h20_0000 + 64'($urandom_range(0, 4095));
      int    iw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_req(v, gpa, {$urandom, $urandom}, ($urandom_range(0, 7) == 0),
             iw, ($urandom_range(0, 3) == 0), vmid_t'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)));
      if ($urandom_range(0, 14) == 0) do_inv($urandom_range(0, 3) == 0, vmid_t'($urandom_range(0, 3)));
    end

    // Reset asserted during a walk discards the request and the cache.
    do_req(8'd5, 64'h3000_0000, 64'hC000_0000, 0, 0, 0, 0, 0);
    req_valid_i = 1'b1; req_vmid_i = 8'd6; req_gpa_i = 64'h3100_0000;
    ept_hpa_i = 64'hC100_0000; ept_fault_i = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    check("walk_before_reset", ept_valid_o, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    m_reset();
    check("rst_walk_resp_valid", resp_valid_o, 0);
    check("rst_walk_req_ready", req_ready_o, 1);
    check("rst_walk_ept_valid", ept_valid_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_resp_valid", resp_valid_o, 0);
    do_req(8'd5, 64'h3000_0000, 64'hC200_0000, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ept_req.md
Name: ept_req

Overview:
Client-side requester for the extended page table translate interface. It accepts guest-physical translation requests from the guest MMU/LSU over a valid/ready handshake and checks a small fully-associative VMID-tagged cache of GPA-page to HPA-page mappings. On a miss it drives the EPT translate port, captures the host-physical result or fault, fills the cache, and returns the response over a valid/ready handshake. It sits between the guest memory pipeline and the EPT translator.

Parameters:
ENTRIES, 8, number of cache entries (power of two, 2..32)
PAGE_SHIFT, 12, page-offset width; offset bits pass through untranslated

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  1  translation request valid
req_ready_o  output  1  block can accept a request
req_vmid_i  input  8  requesting VM id
req_gpa_i  input  64  guest physical address
resp_valid_o  output  1  response valid
resp_ready_i  input  1  consumer accepts response
resp_hpa_o  output  64  host physical address (0 when fault)
resp_fault_o  output  1  translation fault
ept_valid_o  output  1  translate_valid to EPT
ept_vmid_o  output  8  vmid to EPT
ept_gpa_o  output  64  page-aligned GPA to EPT
ept_hpa_i  input  64  HPA from EPT (combinational, same cycle)
ept_fault_i  input  1  fault from EPT (same cycle)
inv_valid_i  input  1  invalidate request
inv_all_i  input  1  with inv_valid_i: flush all entries; else flush by inv_vmid_i
inv_vmid_i  input  8  VM id to flush

Behaviour:
- One request in flight. FSM: IDLE -> (accept, hit) RESP; IDLE -> (accept, miss) WALK -> RESP; RESP -> (resp_ready_i) IDLE.
- req_ready_o = 1 only in IDLE. Accept = req_valid_i & req_ready_o; vmid and gpa are registered.
- Lookup is performed in the accept cycle against the registered-entry array. Hit = valid & vmid match & tag == gpa[63:PAGE_SHIFT].
- Hit: resp_valid_o rises the next cycle; resp_hpa_o = {hpn, gpa[PAGE_SHIFT-1:0]}; fault 0.
- WALK (exactly one cycle): ept_valid_o=1, ept_vmid_o=registered vmid, ept_gpa_o=registered gpa with low PAGE_SHIFT bits zeroed. Capture ept_hpa_i[63:PAGE_SHIFT] and ept_fault_i at the clock edge. Miss latency is 2 cycles from accept to resp_valid_o.
- Outside WALK: ept_valid_o=0, ept_vmid_o=0, ept_gpa_o=0.
- Fill on a non-faulting WALK: first invalid entry; if all entries are valid, the round-robin victim pointer, which then increments mod ENTRIES. Faults are never filled. Fault response: resp_fault_o=1, resp_hpa_o=0.
- RESP: outputs held stable until resp_ready_i. Back-to-back operation: the next request can be accepted the cycle after the response handshake, not the same cycle.
- Invalidate: takes effect at the clock edge of any cycle, in any state. It clears the valid bits of matching entries (or all entries).
- If a WALK fill and a matching invalidate occur in the same cycle, the fill is dropped. The response is still returned with the walked value.
- An invalidate during RESP for a hit does not alter the held response.
- Reset: state IDLE, all valid bits 0, victim pointer 0. Outputs: req_ready_o=1 (combinational from IDLE), resp_valid_o=0, resp_hpa_o=0, resp_fault_o=0, ept_valid_o=0, ept_vmid_o=0, ept_gpa_o=0. A reset mid-walk discards the request.

Optional Feature:
EPT_REQ_STATS_EN: adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0].
- hit_cnt_o increments on each accepted hit; miss_cnt_o increments on each accepted miss.
- Both saturate at all-ones and reset to 0. Invalidates do not clear them.
- Without the macro the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package ept_pkg: vmid_t (8b), addr_t (64b), PAGE_SHIFT default constant, state enum {IDLE, WALK, RESP}, tlb_entry_t struct {valid, vmid, tag, hpn}.
- One natural sub-module, ept_tlb: entry array, parallel lookup, fill, victim pointer and invalidate logic.
- ept_req keeps the FSM and handshakes.

Test Plan:
- Reset, then request vmid 3, gpa 0x4000_0123 with EPT returning 0x5000_0000 -> ept_valid_o one cycle with ept_gpa_o=0x4000_0000; resp 2 cycles after accept, hpa 0x5000_0123, fault 0.
- Repeat vmid 3, gpa 0x4000_0FFF -> no ept_valid_o; resp next cycle, hpa 0x5000_0FFF.
- Same gpa with vmid 4 -> miss (VMID isolation). EPT fault=1 -> resp fault 1, hpa 0; repeating the request misses again (faults not cached).
- Fill 9 distinct pages with ENTRIES=8 -> the 9th evicts entry 0; the page-0 request then misses; pages 1..7 still hit.
- inv_valid_i with inv_vmid_i=3 in the same cycle as a vmid-3 WALK -> response correct, the following identical request misses. inv_all_i -> all subsequent requests miss.
- Hold resp_ready_i=0 for 5 cycles -> resp outputs stable, req_ready_o=0. Assert rst_n low during WALK -> next cycle resp_valid_o=0, req_ready_o=1.
